hoeraa_err_monitor: RTL

- Sequential error-characterisation block: the consumer end of the approximate-adder datapath.
- Accepts a stream of operand pairs with the approximate sum the adder produced for them.
- For each sample it recomputes the exact sum and the error distance (ED).
- Over a run of programmable length it accumulates erroneous-result count, total ED and maximum ED, then presents them to the characterisation controller.

---
 rtl/hoeraa_err_monitor.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/hoeraa_err_monitor.sv
`default_nettype none
// ============================================================================
// Module   : hoeraa_err_monitor
// Purpose  : Error characterisation for an approximate adder: per-sample error
//            distance, accumulated over a programmable-length run.
// Revision : 1.0  initial release
// ============================================================================
module hoeraa_err_monitor #(
    parameter int WIDTH = 12,
    parameter int CNT_W = 16,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH:0]   in_sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] samples_seen,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] sum_ed,
    output logic [WIDTH:0]   max_ed
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Saturation compare width must hold both the accumulator and one ED term.
    localparam int SW = ((ACC_W > WIDTH + 1) ? ACC_W : WIDTH + 1) + 1;
    localparam logic [SW-1:0] C_SAT = {{(SW - ACC_W){1'b0}}, {ACC_W{1'b1}}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] seen_q, seen_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [WIDTH:0]   max_q, max_d;

    logic             s1_v_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    logic [WIDTH:0]   s1_s_q;
    logic             s2_v_q;
    logic [WIDTH:0]   s2_ed_q;

    logic             w_xfer;
    logic             w_start_ok;
    logic [WIDTH:0]   w_exact;
    logic [WIDTH:0]   w_ed;
    logic [SW-1:0]    w_sum_ext;

    assign in_ready   = (state_q == S_RUN) && (seen_q < num_q);
    assign w_xfer     = in_valid && in_ready;
    assign w_start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // S2 arithmetic, operating on the S1 registers.
    assign w_exact   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    assign w_ed      = (w_exact >= s1_s_q) ? (w_exact - s1_s_q) : (s1_s_q - w_exact);
    assign w_sum_ext = SW'(sum_q) + SW'(s2_ed_q);

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        seen_d  = seen_q;
        err_d   = err_q;
        sum_d   = sum_q;
        max_d   = max_q;

        if (s2_v_q) begin
            if (s2_ed_q != '0) begin
                err_d = err_q + CNT_W'(1);
            end
            sum_d = (w_sum_ext > C_SAT) ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
            if (s2_ed_q > max_q) begin
                max_d = s2_ed_q;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (w_start_ok) begin
                    num_d   = num_samples;
                    seen_d  = '0;
                    err_d   = '0;
                    sum_d   = '0;
                    max_d   = '0;
                    state_d = (num_samples == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_xfer) begin
                    seen_d = seen_q + CNT_W'(1);
                    if ((seen_q + CNT_W'(1)) == num_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // S1 empty means the last S2 update lands on this same edge.
                if (!s1_v_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            seen_q  <= '0;
            err_q   <= '0;
            sum_q   <= '0;
            max_q   <= '0;
            s1_v_q  <= 1'b0;
            s1_a_q  <= '0;
            s1_b_q  <= '0;
            s1_s_q  <= '0;
            s2_v_q  <= 1'b0;
            s2_ed_q <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            seen_q  <= seen_d;
            err_q   <= err_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            s1_v_q  <= w_xfer;
            if (w_xfer) begin
                s1_a_q <= in_a;
                s1_b_q <= in_b;
                s1_s_q <= in_sum;
            end
            s2_v_q  <= s1_v_q;
            s2_ed_q <= w_ed;
        end
    end

    assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done         = (state_q == S_DONE);
    assign samples_seen = seen_q;
    assign err_count    = err_q;
    assign sum_ed       = sum_q;
    assign max_ed       = max_q;

endmodule
`default_nettype wire
